// File: rtl/branch_metric_pipe.sv
// ----------------------------------------------------------------------------
// branch_metric_pipe
//
// Computes the branch metrics for one radix-2 or radix-4 trellis step per
// cycle from received soft-decision bits. There are two register stages
// with valid/ready flow control, a global enable and a per-frame symbol
// counter.
//
// Parameters
//   SOFT_W  soft bits per received code bit (1..4, 1 = hard decision)
//   RADIX   2 or 4 (S = 1 or 2 trellis steps per cycle)
//   CNT_W   width of the output symbol counter
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   en_branch   global enable; 0 freezes every stage and the counter
//   i_valid     input word valid
//   o_ready_in  block can accept an input word
//   i_Rx        2*S soft values, oldest in the MSBs
//   i_erase     per-bit erasure flags, same order as i_Rx
//   i_last      final word of a frame
//   HD          NM metrics, metric j at HD[j*MW +: MW]
//   o_valid     HD valid
//   i_ready     downstream accepts HD
//   o_last      i_last aligned with HD
//   o_sym_cnt   output words transferred in the current frame
// ----------------------------------------------------------------------------
module branch_metric_pipe #(
    parameter  int SOFT_W = 3,
    parameter  int RADIX  = 4,
    parameter  int CNT_W  = 16,
    localparam int S      = (RADIX == 4) ? 2 : 1,
    localparam int NM     = 4 ** S,
    localparam int MW     = SOFT_W + S
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_branch,
    input  logic                    i_valid,
    output logic                    o_ready_in,
    input  logic [2*S*SOFT_W-1:0]   i_Rx,
    input  logic [2*S-1:0]          i_erase,
    input  logic                    i_last,
    output logic [NM*MW-1:0]        HD,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_last,
    output logic [CNT_W-1:0]        o_sym_cnt
);

    localparam int                NB = 2 * S;
    localparam logic [SOFT_W-1:0] MX = '1;

    // Stage 1: per-bit distances for both hypotheses of every received bit.
    logic                         r_v1;
    logic                         r_last1;
    logic [NB-1:0][SOFT_W-1:0]    r_d0;
    logic [NB-1:0][SOFT_W-1:0]    r_d1;

    // Stage 2: summed metrics.
    logic                         r_v2;
    logic                         r_last2;
    logic [NM*MW-1:0]             r_hd;
    logic [CNT_W-1:0]             r_cnt;

    logic                         w_s2_ld;
    logic                         w_s1_ld;
    logic                         w_in_xfer;
    logic                         w_out_xfer;
    logic [NB-1:0][SOFT_W-1:0]    w_d0;
    logic [NB-1:0][SOFT_W-1:0]    w_d1;
    logic [NM*MW-1:0]             w_hd;
    logic [MW-1:0]                w_acc;

    // A stage may load when it is empty or its contents move on this edge.
    // Every load is qualified by the enable, so en_branch=0 freezes the pipe.
    assign w_s2_ld    = en_branch & (~r_v2 | i_ready);
    assign w_s1_ld    = en_branch & (~r_v1 | w_s2_ld);
    assign o_ready_in = w_s1_ld & ~rst;
    assign w_in_xfer  = i_valid & o_ready_in;
    assign w_out_xfer = en_branch & r_v2 & i_ready;

    // Distance to expected 0 is r and distance to expected 1 is Mx-r. An
    // erased bit contributes nothing to either hypothesis.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        w_d0 = '0;
        w_d1 = '0;
        for (int p = 0; p < NB; p++) begin
            if (!i_erase[p]) begin
                w_d0[p] = i_Rx[p*SOFT_W +: SOFT_W];
                w_d1[p] = MX - i_Rx[p*SOFT_W +: SOFT_W];
            end
        end
    end

    // Bit p of metric index j selects the hypothesis for received bit p.
    // This keeps the index MSB-first and aligned with the i_Rx ordering.
    // The sum of 2*S values, each at most Mx, always fits in MW bits.
    always_comb begin
        w_hd  = '0;
        w_acc = '0;
        for (int j = 0; j < NM; j++) begin
            w_acc = '0;
            for (int p = 0; p < NB; p++) begin
                if (((j >> p) & 1) != 0)
                    w_acc = w_acc + MW'(r_d1[p]);
                else
                    w_acc = w_acc + MW'(r_d0[p]);
            end
            w_hd[j*MW +: MW] = w_acc;
        end
    end

    // Control state, outputs and counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so
        // every register samples the values from before the edge.
        if (rst) begin
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_v2    <= 1'b0;
            r_last2 <= 1'b0;
            r_hd    <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_s1_ld) begin
                r_v1    <= w_in_xfer;
                r_last1 <= w_in_xfer & i_last;
            end
            if (w_s2_ld) begin
                r_v2    <= r_v1;
                r_last2 <= r_v1 & r_last1;
                // An empty stage 2 drives zero metrics.
                r_hd    <= r_v1 ? w_hd : '0;
            end
            if (w_out_xfer)
                r_cnt <= r_last2 ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // NOTE: the stage-1 distance registers are datapath only. The valid flag
    // guards them, so they have no reset and they load only with a word.
    always_ff @(posedge clk) begin
        if (w_s1_ld && w_in_xfer) begin
            r_d0 <= w_d0;
            r_d1 <= w_d1;
        end
    end

    assign HD        = r_hd;
    assign o_valid   = r_v2;
    assign o_last    = r_last2;
    assign o_sym_cnt = r_cnt;

endmodule

// File: tb/tb_branch_metric_pipe.sv
// ----------------------------------------------------------------------------
// tb_branch_metric_pipe
//
// Self-checking bench for branch_metric_pipe. It uses three instances:
//   u_main  SOFT_W=3, RADIX=4, CNT_W=2  random streams, flow control,
//                                       enable, reset and the frame counter
//   u_hard  SOFT_W=1, RADIX=4           hard-decision metric vector
//   u_t2    SOFT_W=3, RADIX=2           radix-2 vectors, with and without
//                                       erasure
// Expected metrics for u_main come from an arithmetic model of the metric
// definition. The model keeps a queue of words in flight, and the occupancy
// of that queue gives the expected ready behaviour.
// ----------------------------------------------------------------------------
module tb_branch_metric_pipe;

    typedef struct {
        logic [79:0] hd;
        logic        last;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // u_main
    logic        m_en, m_valid, m_last, m_rdy;
    logic [11:0] m_rx;
    logic [3:0]  m_er;
    logic        m_ready, m_ov, m_olast;
    logic [79:0] m_hd;
    logic [1:0]  m_cnt;

    // u_hard
    logic        hd_valid;
    logic [3:0]  hd_rx;
    logic [3:0]  hd_er;
    logic        hd_ready, hd_ov, hd_olast;
    logic [47:0] hd_hd;
    logic [15:0] hd_cnt;

    // u_t2
    logic        t2_valid;
    logic [5:0]  t2_rx;
    logic [1:0]  t2_er;
    logic        t2_ready, t2_ov, t2_olast;
    logic [15:0] t2_hd;
    logic [15:0] t2_cnt;

    int          checks = 0;
    int          errors = 0;
    word_t       exp_q[$];
    logic [1:0]  exp_cnt;
    logic        prev_hold, prev_en, prev_ov, prev_out;
    int          accepted;
    logic [1:0]  cnt_log[$];

    branch_metric_pipe #(.SOFT_W(3), .RADIX(4), .CNT_W(2)) u_main (
        .clk(clk), .rst(rst), .en_branch(m_en), .i_valid(m_valid),
        .o_ready_in(m_ready), .i_Rx(m_rx), .i_erase(m_er), .i_last(m_last),
        .HD(m_hd), .o_valid(m_ov), .i_ready(m_rdy), .o_last(m_olast),
        .o_sym_cnt(m_cnt)
    );

    branch_metric_pipe #(.SOFT_W(1), .RADIX(4), .CNT_W(16)) u_hard (
        .clk(clk), .rst(rst), .en_branch(1'b1), .i_valid(hd_valid),
        .o_ready_in(hd_ready), .i_Rx(hd_rx), .i_erase(hd_er), .i_last(1'b0),
        .HD(hd_hd), .o_valid(hd_ov), .i_ready(1'b1), .o_last(hd_olast),
        .o_sym_cnt(hd_cnt)
    );

    branch_metric_pipe #(.SOFT_W(3), .RADIX(2), .CNT_W(16)) u_t2 (
        .clk(clk), .rst(rst), .en_branch(1'b1), .i_valid(t2_valid),
        .o_ready_in(t2_ready), .i_Rx(t2_rx), .i_erase(t2_er), .i_last(1'b0),
        .HD(t2_hd), .o_valid(t2_ov), .i_ready(1'b1), .o_last(t2_olast),
        .o_sym_cnt(t2_cnt)
    );

    // Metric j is the sum over the four received bits of r (expected 0) or
    // 7-r (expected 1). Erased bits contribute 0. Bit p of j is the
    // expected value of soft value p, where p=0 is the newest (LSB) one.
    function automatic logic [79:0] model_hd(logic [11:0] rx, logic [3:0] er);
        logic [79:0] v;
        int          sum;
        int          r;
        v = '0;
        for (int j = 0; j < 16; j++) begin
            sum = 0;
            for (int p = 0; p < 4; p++) begin
                r = int'((rx >> (3 * p)) & 12'd7);
                if (!er[p]) sum += (((j >> p) & 1) != 0) ? (7 - r) : r;
            end
            v[j*5 +: 5] = sum[4:0];
        end
        return v;
    endfunction

    function automatic void reset_model();
        exp_q.delete();
        exp_cnt   = 2'd0;
        prev_hold = 1'b0;
        prev_en   = 1'b1;
        prev_ov   = 1'b0;
        prev_out  = 1'b0;
    endfunction

    // Advances u_main by one cycle. Inputs are driven after the falling
    // edge, outputs are checked against the model, and the model then
    // applies the transfers that the next rising edge will perform.
    task automatic step(input logic v, input logic l, input logic [11:0] rx,
                        input logic [3:0] er, input logic en, input logic rdy);
        logic  out_x;
        logic  exp_rdy;
        word_t w;
        @(negedge clk);
        m_valid = v; m_last = l; m_rx = rx; m_er = er; m_en = en; m_rdy = rdy;
        #1;
        if (prev_out) cnt_log.push_back(m_cnt);

        checks++;
        if (m_ov === 1'b1 && exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_word: o_valid=1 with no word expected, HD=%h", m_hd);
        end else if (m_ov === 1'b1 &&
                     (m_hd !== exp_q[0].hd || m_olast !== exp_q[0].last)) begin
            errors++;
            $display("FAIL out_word: HD=%h last=%b, wanted HD=%h last=%b",
                     m_hd, m_olast, exp_q[0].hd, exp_q[0].last);
        end

        checks++;
        if (m_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL sym_cnt: got %0d wanted %0d", m_cnt, exp_cnt);
        end

        // The pipe holds at most two words. It can take another when fewer
        // than two are inside, or when one leaves on this edge.
        exp_rdy = en & ((exp_q.size() < 2) | rdy);
        checks++;
        if (m_ready !== exp_rdy) begin
            errors++;
            $display("FAIL ready_in: got %b wanted %b (occupancy %0d en %b rdy %b)",
                     m_ready, exp_rdy, exp_q.size(), en, rdy);
        end

        if (prev_hold) begin
            checks++;
            if (m_ov !== 1'b1) begin
                errors++;
                $display("FAIL valid_hold: o_valid=%b after a refused word, wanted 1", m_ov);
            end
        end
        if (!prev_en) begin
            checks++;
            if (m_ov !== prev_ov) begin
                errors++;
                $display("FAIL freeze_valid: o_valid=%b, wanted %b", m_ov, prev_ov);
            end
        end

        out_x     = en & (m_ov === 1'b1) & rdy;
        prev_hold = (m_ov === 1'b1) & ~out_x;
        prev_en   = en;
        prev_ov   = m_ov;
        prev_out  = out_x;
        if (out_x && exp_q.size() > 0) begin
            exp_cnt = exp_q[0].last ? 2'd0 : exp_cnt + 2'd1;
            void'(exp_q.pop_front());
        end
        if (en && v && m_ready === 1'b1) begin
            w.hd   = model_hd(rx, er);
            w.last = l;
            exp_q.push_back(w);
            accepted++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            step(1'b0, 1'b0, 12'd0, 4'd0, 1'b1, 1'b1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d words never left the pipe, wanted 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_en = 1'b1; m_valid = 1'b1; m_last = 1'b0; m_rdy = 1'b1;
        m_rx = 12'hfff; m_er = 4'd0;
        hd_valid = 1'b0; hd_rx = 4'd0; hd_er = 4'd0;
        t2_valid = 1'b0; t2_rx = 6'd0; t2_er = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_ov !== 1'b0 || m_hd !== 80'd0 || m_cnt !== 2'd0 || m_olast !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ov=%b hd=%h cnt=%0d last=%b, wanted all 0",
                     m_ov, m_hd, m_cnt, m_olast);
        end
        checks++;
        if (m_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: o_ready_in=%b during rst, wanted 0", m_ready);
        end
        checks++;
        if (hd_ov !== 1'b0 || t2_ov !== 1'b0) begin
            errors++;
            $display("FAIL reset_aux: hard ov=%b r2 ov=%b, wanted 0", hd_ov, t2_ov);
        end
        m_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (m_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: o_ready_in=%b, wanted 1", m_ready);
        end
        reset_model();
    endtask

    task automatic test_vectors();
        int hidx[5] = '{0, 3, 12, 15, 5};
        int hexp[5] = '{2, 0, 4, 2, 2};
        int e0[4]   = '{7, 14, 0, 7};
        int e1[4]   = '{0, 7, 0, 7};
        @(negedge clk);
        hd_valid = 1'b1; hd_rx = 4'b0011; hd_er = 4'd0;
        t2_valid = 1'b1; t2_rx = {3'd7, 3'd0}; t2_er = 2'b00;
        @(negedge clk);
        hd_valid = 1'b0;
        t2_er = 2'b10;
        #1;
        checks++;
        if (hd_ov !== 1'b0 || t2_ov !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: ov hard=%b r2=%b one cycle after input, wanted 0",
                     hd_ov, t2_ov);
        end
        @(negedge clk);
        t2_valid = 1'b0;
        #1;
        checks++;
        if (hd_ov !== 1'b1 || t2_ov !== 1'b1) begin
            errors++;
            $display("FAIL latency: ov hard=%b r2=%b two cycles after input, wanted 1",
                     hd_ov, t2_ov);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (int'(hd_hd[hidx[k]*3 +: 3]) != hexp[k]) begin
                errors++;
                $display("FAIL hard_metric[%0d]: got %0d wanted %0d",
                         hidx[k], hd_hd[hidx[k]*3 +: 3], hexp[k]);
            end
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (int'(t2_hd[j*4 +: 4]) != e0[j]) begin
                errors++;
                $display("FAIL r2_metric[%0d]: got %0d wanted %0d", j, t2_hd[j*4 +: 4], e0[j]);
            end
        end
        @(negedge clk);
        #1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (int'(t2_hd[j*4 +: 4]) != e1[j]) begin
                errors++;
                $display("FAIL r2_erase_metric[%0d]: got %0d wanted %0d",
                         j, t2_hd[j*4 +: 4], e1[j]);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (t2_ov !== 1'b0 || t2_hd !== 16'd0) begin
            errors++;
            $display("FAIL empty_zero: r2 ov=%b HD=%h once empty, wanted 0 and 0", t2_ov, t2_hd);
        end
    endtask

    task automatic test_latency();
        step(1'b1, 1'b0, 12'h5a3, 4'b0100, 1'b1, 1'b1);
        step(1'b0, 1'b0, 12'd0, 4'd0, 1'b1, 1'b1);
        checks++;
        if (m_ov !== 1'b0) begin
            errors++;
            $display("FAIL main_latency_early: o_valid=%b, wanted 0", m_ov);
        end
        step(1'b0, 1'b0, 12'd0, 4'd0, 1'b1, 1'b1);
        checks++;
        if (m_ov !== 1'b1) begin
            errors++;
            $display("FAIL main_latency: o_valid=%b, wanted 1", m_ov);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int start;
        start = accepted;
        for (int c = 0; c < 10; c++) begin
            step((accepted - start) < 5, 1'b0, 12'($urandom), 4'($urandom_range(0, 15)),
                 1'b1, !(c >= 2 && c < 5));
            if (c == 2) begin
                checks++;
                if (m_ready !== 1'b0 || m_ov !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_full: ready=%b ov=%b with both stages full, wanted 0 and 1",
                             m_ready, m_ov);
                end
            end
        end
        drain();
        checks++;
        if (accepted - start != 5) begin
            errors++;
            $display("FAIL bp_count: accepted %0d words, wanted 5", accepted - start);
        end
    endtask

    task automatic test_freeze();
        for (int c = 0; c < 10; c++)
            step(1'b1, 1'b0, 12'($urandom), 4'd0, !(c == 3 || c == 4), 1'b1);
        drain();
    endtask

    task automatic test_random_stream();
        int start;
        start = accepted;
        for (int c = 0; c < 400; c++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0, 12'($urandom),
                 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7);
        drain();
        checks++;
        if (accepted - start < 100) begin
            errors++;
            $display("FAIL random_progress: only %0d words accepted, wanted at least 100",
                     accepted - start);
        end
    endtask

    task automatic test_reset_midstream();
        for (int c = 0; c < 3; c++)
            step(1'b1, 1'b0, 12'($urandom), 4'd0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 12'($urandom), 4'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 12'($urandom), 4'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        m_en = 1'b1; m_valid = 1'b1; m_rdy = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (m_ov !== 1'b0 || m_cnt !== 2'd0 || m_hd !== 80'd0) begin
            errors++;
            $display("FAIL reset_midstream: ov=%b cnt=%0d hd=%h, wanted 0 0 0",
                     m_ov, m_cnt, m_hd);
        end
        checks++;
        if (m_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_midstream_ready: o_ready_in=%b, wanted 0", m_ready);
        end
        @(negedge clk);
        m_valid = 1'b0;
        rst = 1'b0;
        reset_model();
        for (int c = 0; c < 4; c++)
            step(1'b0, 1'b0, 12'd0, 4'd0, 1'b1, 1'b1);
    endtask

    task automatic test_frame_counter();
        int start;
        int want[5] = '{1, 2, 3, 0, 0};
        cnt_log.delete();
        start = accepted;
        for (int c = 0; c < 12 && (accepted - start) < 5; c++)
            step(1'b1, (accepted - start) == 4, 12'($urandom), 4'd0, 1'b1, 1'b1);
        drain();
        step(1'b0, 1'b0, 12'd0, 4'd0, 1'b1, 1'b1);
        checks++;
        if (cnt_log.size() != 5) begin
            errors++;
            $display("FAIL frame_transfers: %0d transfers seen, wanted 5", cnt_log.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (int'(cnt_log[k]) != want[k]) begin
                    errors++;
                    $display("FAIL frame_cnt[%0d]: got %0d wanted %0d", k, cnt_log[k], want[k]);
                end
            end
        end
    endtask

    initial begin
        accepted = 0;
        reset_model();
        test_reset();
        test_vectors();
        test_latency();
        test_backpressure();
        test_freeze();
        test_random_stream();
        test_reset_midstream();
        test_frame_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_metric_pipe.md
BRANCH_METRIC_PIPE -- requirements
Module: branch_metric_pipe

Interface
REQ-001 SHALL provide parameter SOFT_W, default 3, soft-decision bits per received code bit, legal 1..4; a value of 1 means hard decision.
REQ-002 SHALL provide parameter RADIX, default 4, trellis steps per cycle as radix, legal 2 or 4; S = 1 for radix-2 and 2 for radix-4.
REQ-003 SHALL provide parameter CNT_W, default 16, width of the symbol counter.
REQ-004 SHALL derive localparams NM = 4^S (metric count) and MW = SOFT_W+S (metric width).
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, reset; synchronous, active-high.
- en_branch, in, 1, global enable; 0 freezes the block.
- i_valid, in, 1, input word valid.
- o_ready_in, out, 1, block can accept an input word.
- i_Rx, in, 2*S*SOFT_W, received soft bits; the oldest bit is in the MSBs.
- i_erase, in, 2*S, per-bit puncture flag with the same ordering as i_Rx; 1 means erased.
- i_last, in, 1, marks the final word of a frame.
- HD, out, NM*MW, metric j at HD[j*MW +: MW].
- o_valid, out, 1, HD valid.
- i_ready, in, 1, downstream accepts HD.
- o_last, out, 1, i_last delayed alongside its word.
- o_sym_cnt, out, CNT_W, count of output words transferred in the current frame.

Function
REQ-006 Soft value r SHALL be unsigned: 0 = strongest 0, Mx = 2^SOFT_W-1 = strongest 1.
REQ-007 Per-bit distance SHALL be:
- r when the expected bit is 0.
- Mx-r when the expected bit is 1.
- 0 when the matching i_erase bit is 1.
REQ-008 Metric index j SHALL be formed from 2*S expected bits, MSB-first, aligned bit-for-bit with i_Rx ordering (radix-4: j[3:2] = expected older pair, j[1:0] = expected newer pair).
REQ-009 HD[j] SHALL equal the sum of the 2*S per-bit distances for index j.
- No overflow is possible because MW = SOFT_W+S; no saturation logic.
REQ-010 Pipeline SHALL have two register stages:
- S1: registers the per-bit distances for both expected values, plus the valid and last flags.
- S2: registers HD, o_valid and o_last.
REQ-011 An input transfer SHALL occur on a clk edge with i_valid & o_ready_in & en_branch; the resulting HD SHALL appear with o_valid=1 exactly 2 cycles later when unstalled.
REQ-012 Stage advance:
- S2 loads when S2 is empty or i_ready=1.
- S1 loads when S1 is empty or S2 loads.
- o_ready_in = en_branch & (S1 empty | S2 loads).
REQ-013 While o_valid=1 and i_ready=0:
- HD, o_last and o_valid SHALL hold stable.
- No word SHALL be dropped or duplicated, and order SHALL be preserved.
REQ-014 Full throughput SHALL be one word per cycle when i_ready is held at 1.
REQ-015 When en_branch=0:
- o_ready_in=0.
- No stage SHALL advance, including when i_ready=1.
- o_valid, HD, o_last and o_sym_cnt SHALL hold.
REQ-016 An output transfer is o_valid & i_ready & en_branch.
- Each output transfer SHALL increment o_sym_cnt, wrapping from 2^CNT_W-1 to 0.
- A transfer with o_last=1 SHALL load o_sym_cnt with 0 instead.
REQ-017 When the S2 register is empty, HD SHALL drive 0.
REQ-018 Simultaneous input and output transfer on a full pipeline SHALL be legal and lossless.

Reset
REQ-019 On a clk edge with rst=1, the block SHALL clear:
- o_valid, o_last, HD, o_sym_cnt and both stage valid flags to 0.
- Any in-flight words are discarded.
REQ-020 During rst=1, o_ready_in SHALL be 0; it SHALL be able to assert in the first cycle after rst deasserts.
REQ-021 rst SHALL take priority over en_branch and all handshakes.

Verification
REQ-022 SOFT_W=1, RADIX=4, i_Rx=4'b0011, no erase -> after 2 cycles:
- HD[0]=2, HD[3]=0, HD[12]=4, HD[15]=2, HD[5]=2.
REQ-023 SOFT_W=3, RADIX=2, i_Rx={3'd7,3'd0}:
- With no erase -> HD[0..3] = 7, 14, 0, 7.
- With i_erase=2'b10 -> HD[0..3] = 0, 7, 0, 7.
REQ-024 Backpressure:
- Stimulus: stream 5 words, with i_ready=0 for 3 cycles after the first o_valid.
- Response: o_ready_in drops once S1 and S2 are full, HD holds, and all 5 words exit in order with no loss.
REQ-025 en_branch=0 for 2 cycles mid-stream -> o_ready_in=0 and no stage or counter changes; the stream then resumes intact.
REQ-026 Reset mid-stream:
- Stimulus: rst=1 with 2 words in flight.
- Response: next cycle o_valid=0, o_sym_cnt=0 and HD=0; the in-flight words never appear.
REQ-027 Frame counter:
- CNT_W=2, 5 words with i_last on the 5th -> o_sym_cnt reads 1, 2, 3, 0 after transfers 1-4 (wrap), then 0 after the last.
